// File: rtl/scu_timers_pkg.sv
// Shared SCU timer types: counter widths, Timer 1 mode register layout and FSM states.
package scu_timers_pkg;

  localparam int T0_CNT_W = 10;
  localparam int T1_CNT_W = 9;

  // ENB gates both timers; MD=1 restricts Timer 1 to lines where Timer 0 matched.
  typedef struct packed {
    logic enb;
    logic md;
  } T1MD_t;

  typedef enum logic {
    T1_IDLE  = 1'b0,
    T1_COUNT = 1'b1
  } t1_state_t;

endpackage

// File: rtl/scu_timers_if.sv
// Register-file and video-timing inputs into the SCU timers, IRQ pulses and status out.
interface scu_timers_if
  import scu_timers_pkg::*;
#(
  parameter int T0_W = T0_CNT_W,
  parameter int T1_W = T1_CNT_W
);

  logic            ce;
  logic            dot_ce;
  logic            hblank;
  logic            vblank;
  logic [T0_W-1:0] t0c;
  logic [T1_W-1:0] t1s;
  T1MD_t           t1md;
  logic            t0_irq;
  logic            t1_irq;
  logic [T0_W-1:0] t0_cnt;

  modport master (
    output ce, dot_ce, hblank, vblank, t0c, t1s, t1md,
    input  t0_irq, t1_irq, t0_cnt
  );

  modport slave (
    input  ce, dot_ce, hblank, vblank, t0c, t1s, t1md,
    output t0_irq, t1_irq, t0_cnt
  );

endinterface

// File: rtl/scu_edge_det.sv
// Registered single-edge detector on a level input; pulse appears 1 CE cycle after the edge is sampled.
// State only advances on CE, so the pulse holds while CE=0.
module scu_edge_det #(
  parameter bit RISING = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ce,
  input  logic d,
  output logic pulse
);

  logic d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q   <= 1'b0;
      pulse <= 1'b0;
    end else if (ce) begin
      d_q   <= d;
      pulse <= RISING ? (d & ~d_q) : (~d & d_q);
    end
  end

endmodule

// File: rtl/scu_timers.sv
// SCU Timer 0 (line counter with compare) and Timer 1 (per-line dot countdown) with IRQ pulses.
// T0_IRQ 2 CE cycles after the blanking edge is sampled; T1_IRQ 1 CE after the expiring DOT_CE.
module scu_timers
  import scu_timers_pkg::*;
#(
  parameter int T0_W = T0_CNT_W,
  parameter int T1_W = T1_CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  scu_timers_if.slave  bus
);

  logic            hb_in;
  logic            vb_out;
  logic            t0_upd;
  logic            t0_hit;
  logic [T0_W-1:0] t0;
  logic [T0_W-1:0] t0_next;
  logic            line_match;
  logic            t0_irq_q;
  logic [T1_W-1:0] t1;
  t1_state_t       t1_state;
  logic            t1_irq_q;

  scu_edge_det #(.RISING(1'b1)) u_hb_det (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (bus.ce),
    .d     (bus.hblank),
    .pulse (hb_in)
  );

  scu_edge_det #(.RISING(1'b0)) u_vb_det (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (bus.ce),
    .d     (bus.vblank),
    .pulse (vb_out)
  );

  // VBlank-out wins over a coincident HBlank-in; the compare always sees the post-update count.
  always_comb begin
    t0_upd  = hb_in | vb_out;
    t0_next = vb_out ? '0 : t0 + T0_W'(1);
    t0_hit  = t0_upd && (t0_next == bus.t0c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t0         <= '0;
      line_match <= 1'b0;
      t0_irq_q   <= 1'b0;
    end else if (bus.ce) begin
      if (!bus.t1md.enb) begin
        t0         <= '0;
        line_match <= 1'b0;
        t0_irq_q   <= 1'b0;
      end else begin
        if (t0_upd) begin
          t0 <= t0_next;
        end
        if (hb_in) begin
          line_match <= t0_hit;
        end else if (t0_hit) begin
          line_match <= 1'b1;
        end
        t0_irq_q <= t0_hit;
      end
    end
  end

  // A new line always reloads, even while a countdown is still pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t1       <= '0;
      t1_state <= T1_IDLE;
      t1_irq_q <= 1'b0;
    end else if (bus.ce) begin
      t1_irq_q <= 1'b0;
      if (!bus.t1md.enb) begin
        t1_state <= T1_IDLE;
      end else if (hb_in) begin
        t1       <= bus.t1s;
        t1_state <= T1_COUNT;
      end else begin
        case (t1_state)
          T1_IDLE: t1_state <= T1_IDLE;
          T1_COUNT: begin
            if (bus.dot_ce) begin
              if (t1 != '0) begin
                t1 <= t1 - T1_W'(1);
              end else begin
                t1_irq_q <= ~bus.t1md.md | line_match;
                t1_state <= T1_IDLE;
              end
            end
          end
          default: t1_state <= T1_IDLE;
        endcase
      end
    end
  end

  assign bus.t0_irq = t0_irq_q;
  assign bus.t1_irq = t1_irq_q;
  assign bus.t0_cnt = t0;

endmodule

// File: tb/tb_scu_timers.sv
// Self-checking bench for scu_timers: directed scenarios plus randomized traffic against a line/dot reference model.
module tb_scu_timers;
  import scu_timers_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  scu_timers_if #(.T0_W(T0_CNT_W), .T1_W(T1_CNT_W)) bus ();

  scu_timers #(.T0_W(T0_CNT_W), .T1_W(T1_CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: blanking edges become line events one CE later; events drive the counters.
  bit       p_hb = 0, p_vb = 0, ev_hb = 0, ev_vb = 0;
  bit       m_lm = 0, m_armed = 0, m_irq0 = 0, m_irq1 = 0;
  logic [9:0] m_t0 = '0;
  int       m_t1 = 0;

  task automatic model_reset();
    p_hb = 0; p_vb = 0; ev_hb = 0; ev_vb = 0;
    m_lm = 0; m_armed = 0; m_irq0 = 0; m_irq1 = 0;
    m_t0 = '0; m_t1 = 0;
  endtask

  task automatic model_step();
    bit hb_e, vb_e, lm_old;
    hb_e   = bus.hblank && !p_hb;
    vb_e   = !bus.vblank && p_vb;
    p_hb   = bus.hblank;
    p_vb   = bus.vblank;
    lm_old = m_lm;
    m_irq0 = 0;
    m_irq1 = 0;
    if (!bus.t1md.enb) begin
      m_t0 = '0; m_lm = 0; m_armed = 0;
    end else begin
      if (ev_vb) m_t0 = '0;
      else if (ev_hb) m_t0 = m_t0 + 10'd1;
      if (ev_hb) m_lm = 0;
      if ((ev_vb || ev_hb) && m_t0 == bus.t0c) begin
        m_irq0 = 1; m_lm = 1;
      end
      if (ev_hb) begin
        m_t1 = int'(bus.t1s); m_armed = 1;
      end else if (m_armed && bus.dot_ce) begin
        if (m_t1 > 0) m_t1 = m_t1 - 1;
        else begin
          m_irq1 = !bus.t1md.md || lm_old;
          m_armed = 0;
        end
      end
    end
    ev_hb = hb_e;
    ev_vb = vb_e;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else if (bus.ce) model_step();
  end

  task automatic drive(input bit hb, input bit vb, input bit dot);
    bus.hblank = hb;
    bus.vblank = vb;
    bus.dot_ce = dot;
  endtask

  function automatic bit hb_wave(input int pos, input int len, input int hw);
    int p;
    p = pos % len;
    return (p >= 1) && (p <= hw);
  endfunction

  task automatic set_regs(input bit enb, input bit md, input int t0c, input int t1s);
    bus.t1md.enb = enb;
    bus.t1md.md  = md;
    bus.t0c      = 10'(t0c);
    bus.t1s      = 9'(t1s);
  endtask

  task automatic test_reset();
    bus.ce = 1'b1;
    drive(0, 0, 0);
    set_regs(0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.t0_irq !== 1'b0) begin errors++; $display("FAIL reset_t0_irq got %b want 0", bus.t0_irq); end
    checks++;
    if (bus.t1_irq !== 1'b0) begin errors++; $display("FAIL reset_t1_irq got %b want 0", bus.t1_irq); end
    checks++;
    if (bus.t0_cnt !== 10'd0) begin errors++; $display("FAIL reset_t0_cnt got %0d want 0", bus.t0_cnt); end
    rst_n = 1'b1;
  endtask

  task automatic test_t0_match();
    int n0 = 0;
    logic [9:0] last = '1;
    set_regs(1, 0, 5, 3);
    for (int c = 0; c < 206; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.t0_irq, bus.t1_irq, bus.t0_cnt} !== {m_irq0, m_irq1, m_t0}) begin
        errors++; $display("FAIL t0match_cycle%0d got %b/%b/%0d want %b/%b/%0d", c, bus.t0_irq, bus.t1_irq, bus.t0_cnt, m_irq0, m_irq1, m_t0);
      end
      if (bus.t0_irq) begin
        n0++;
        checks++;
        if (bus.t0_cnt !== 10'd5) begin errors++; $display("FAIL t0match_cnt_at_irq got %0d want 5", bus.t0_cnt); end
      end
      if (bus.t0_cnt !== last) begin
        if (last == 10'd5) begin
          checks++;
          if (bus.t0_cnt !== 10'd6) begin errors++; $display("FAIL t0match_after5 got %0d want 6", bus.t0_cnt); end
        end
        last = bus.t0_cnt;
      end
      if (c < 6) drive(0, c < 4, 0);
      else drive(hb_wave(c - 6, 20, 4), 0, c[0]);
    end
    checks++;
    if (n0 != 1) begin errors++; $display("FAIL t0match_pulses got %0d want 1", n0); end
    checks++;
    if (bus.t0_cnt !== 10'd10) begin errors++; $display("FAIL t0match_final_cnt got %0d want 10", bus.t0_cnt); end
  endtask

  task automatic test_t1_every_line();
    int n1 = 0, last_c = -1;
    set_regs(1, 0, 1000, 3);
    for (int c = 0; c < 8 * 24; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.t0_irq, bus.t1_irq, bus.t0_cnt} !== {m_irq0, m_irq1, m_t0}) begin
        errors++; $display("FAIL t1every_cycle%0d got %b/%b/%0d want %b/%b/%0d", c, bus.t0_irq, bus.t1_irq, bus.t0_cnt, m_irq0, m_irq1, m_t0);
      end
      if (bus.t1_irq) begin
        n1++;
        if (last_c >= 0) begin
          checks++;
          if (c - last_c != 24) begin errors++; $display("FAIL t1every_gap got %0d want 24", c - last_c); end
        end
        last_c = c;
      end
      drive(hb_wave(c, 24, 3), 0, c[0]);
    end
    checks++;
    if (n1 != 8) begin errors++; $display("FAIL t1every_pulses got %0d want 8", n1); end
  endtask

  task automatic test_t1_md1();
    int n1 = 0;
    set_regs(1, 1, 2, 0);
    for (int c = 0; c < 6 + 6 * 16; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.t0_irq, bus.t1_irq, bus.t0_cnt} !== {m_irq0, m_irq1, m_t0}) begin
        errors++; $display("FAIL t1md1_cycle%0d got %b/%b/%0d want %b/%b/%0d", c, bus.t0_irq, bus.t1_irq, bus.t0_cnt, m_irq0, m_irq1, m_t0);
      end
      if (bus.t1_irq) begin
        n1++;
        checks++;
        if (bus.t0_cnt !== 10'd2) begin errors++; $display("FAIL t1md1_line got %0d want 2", bus.t0_cnt); end
      end
      if (c < 6) drive(0, c < 4, 1);
      else drive(hb_wave(c - 6, 16, 3), 0, 1);
    end
    checks++;
    if (n1 != 1) begin errors++; $display("FAIL t1md1_pulses got %0d want 1", n1); end
  endtask

  task automatic test_same_cycle();
    int n0 = 0;
    set_regs(1, 0, 0, 50);
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.t0_irq, bus.t1_irq, bus.t0_cnt} !== {m_irq0, m_irq1, m_t0}) begin
        errors++; $display("FAIL same_cycle%0d got %b/%b/%0d want %b/%b/%0d", c, bus.t0_irq, bus.t1_irq, bus.t0_cnt, m_irq0, m_irq1, m_t0);
      end
      if (bus.t0_irq) n0++;
      if (c < 4) drive(0, 1, 0);
      else drive(c < 7, 0, 0);
    end
    checks++;
    if (n0 != 1) begin errors++; $display("FAIL same_pulses got %0d want 1", n0); end
    checks++;
    if (bus.t0_cnt !== 10'd0) begin errors++; $display("FAIL same_cnt got %0d want 0", bus.t0_cnt); end
  endtask

  task automatic test_short_line_and_disable();
    int n0 = 0, n1 = 0;
    set_regs(1, 0, 1000, 400);
    for (int c = 0; c < 150 + 420; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.t0_irq, bus.t1_irq, bus.t0_cnt} !== {m_irq0, m_irq1, m_t0}) begin
        errors++; $display("FAIL short_cycle%0d got %b/%b/%0d want %b/%b/%0d", c, bus.t0_irq, bus.t1_irq, bus.t0_cnt, m_irq0, m_irq1, m_t0);
      end
      if (bus.t1_irq) n1++;
      if (c == 150) begin
        checks++;
        if (n1 != 0) begin errors++; $display("FAIL short_no_expiry got %0d want 0", n1); end
      end
      drive(c < 150 ? hb_wave(c, 30, 3) : 1'b0, 0, 1);
    end
    checks++;
    if (n1 != 1) begin errors++; $display("FAIL short_reload_expiry got %0d want 1", n1); end
    n1 = 0;
    set_regs(0, 0, 2, 0);
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.t0_irq, bus.t1_irq, bus.t0_cnt} !== {m_irq0, m_irq1, m_t0}) begin
        errors++; $display("FAIL disabled_cycle%0d got %b/%b/%0d want %b/%b/%0d", c, bus.t0_irq, bus.t1_irq, bus.t0_cnt, m_irq0, m_irq1, m_t0);
      end
      if (bus.t0_irq) n0++;
      if (bus.t1_irq) n1++;
      drive(hb_wave(c, 30, 3), 0, 1);
    end
    checks++;
    if (n0 + n1 != 0) begin errors++; $display("FAIL disabled_irqs got %0d want 0", n0 + n1); end
    checks++;
    if (bus.t0_cnt !== 10'd0) begin errors++; $display("FAIL disabled_cnt got %0d want 0", bus.t0_cnt); end
  endtask

  task automatic test_reset_mid();
    int n0 = 0;
    set_regs(1, 0, 20, 400);
    for (int c = 0; c < 6 + 7 * 10; c++) begin
      @(negedge clk);
      if (c < 6) drive(0, c < 4, 0);
      else drive(hb_wave(c - 6, 10, 2), 0, 0);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.t0_cnt !== 10'd7) begin errors++; $display("FAIL rstmid_pre_cnt got %0d want 7", bus.t0_cnt); end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.t0_irq, bus.t1_irq, bus.t0_cnt} !== 12'd0) begin
      errors++; $display("FAIL rstmid_async got %b/%b/%0d want 0/0/0", bus.t0_irq, bus.t1_irq, bus.t0_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.t0c = 10'd3;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.t0_irq, bus.t1_irq, bus.t0_cnt} !== {m_irq0, m_irq1, m_t0}) begin
        errors++; $display("FAIL rstmid_cycle%0d got %b/%b/%0d want %b/%b/%0d", c, bus.t0_irq, bus.t1_irq, bus.t0_cnt, m_irq0, m_irq1, m_t0);
      end
      if (bus.t0_irq) begin
        n0++;
        checks++;
        if (bus.t0_cnt !== 10'd3) begin errors++; $display("FAIL rstmid_match_cnt got %0d want 3", bus.t0_cnt); end
      end
      drive(hb_wave(c, 10, 2), 0, 0);
    end
    checks++;
    if (n0 != 1) begin errors++; $display("FAIL rstmid_pulses got %0d want 1", n0); end
  endtask

  task automatic test_wrap();
    int n0 = 0;
    set_regs(1, 0, 0, 511);
    for (int c = 0; c < 6 + 1024 * 6 + 4; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.t0_irq, bus.t1_irq, bus.t0_cnt} !== {m_irq0, m_irq1, m_t0}) begin
        errors++; $display("FAIL wrap_cycle%0d got %b/%b/%0d want %b/%b/%0d", c, bus.t0_irq, bus.t1_irq, bus.t0_cnt, m_irq0, m_irq1, m_t0);
      end
      if (bus.t0_irq) n0++;
      if (c < 6) drive(0, c < 4, 0);
      else if (c < 6 + 1024 * 6) drive(hb_wave(c - 6, 6, 2), 0, 0);
      else drive(0, 0, 0);
    end
    checks++;
    if (n0 != 2) begin errors++; $display("FAIL wrap_pulses got %0d want 2", n0); end
    checks++;
    if (bus.t0_cnt !== 10'd0) begin errors++; $display("FAIL wrap_cnt got %0d want 0", bus.t0_cnt); end
  endtask

  task automatic test_random();
    int  pos = 0, len = 20, hw = 3, lines = 0;
    bit  vbl = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.t0_irq, bus.t1_irq, bus.t0_cnt} !== {m_irq0, m_irq1, m_t0}) begin
        errors++; $display("FAIL random_cycle%0d got %b/%b/%0d want %b/%b/%0d", c, bus.t0_irq, bus.t1_irq, bus.t0_cnt, m_irq0, m_irq1, m_t0);
      end
      if (pos == 0) begin
        len = $urandom_range(8, 40);
        hw  = $urandom_range(1, 4);
        lines++;
        if (lines % 5 == 0) vbl = ~vbl;
        set_regs(($urandom % 8) != 0, $urandom_range(0, 1), $urandom_range(0, 5), $urandom_range(0, 19));
      end
      bus.ce = ($urandom % 8) != 0;
      drive(hb_wave(pos, len, hw), vbl, $urandom_range(0, 1));
      pos = (pos + 1) % len;
    end
    bus.ce = 1'b1;
  endtask

  initial begin
    test_reset();
    test_t0_match();
    test_t1_every_line();
    test_t1_md1();
    test_same_cycle();
    test_short_line_and_disable();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scu_timers.md
# scu_timers

SCU timer unit: Timer 0 counts video lines and compares the count against T0C. Timer 1 is reloaded from T1S at each line start and counts down on dot ticks. The block raises single-cycle T0 and T1 interrupt-request pulses into the SCU interrupt controller, which sets IST.T0I/T1I subject to IMS. Register values arrive already decoded and masked by the SCU register file.

## Interface
Parameters:
- T0_W, 10, Timer 0 counter/compare width (matches T0C_WMASK).
- T1_W, 9, Timer 1 counter/reload width (matches T1S_WMASK).

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous, active-low reset.
- CE  in  1  clock enable. All state advances only when CE=1.
- DOT_CE  in  1  dot-rate tick, qualified by CE. Timer 1 decrement strobe.
- HBLANK  in  1  VDP2 HBlank level. Rising edge = HBlank-in.
- VBLANK  in  1  VDP2 VBlank level. Falling edge = VBlank-out.
- T0C  in  T0_W  Timer 0 compare value, live from the register file.
- T1S  in  T1_W  Timer 1 reload value, live.
- T1MD  in  T1MD_t  ENB enables both timers. MD selects Timer 1 mode: 0 = fire every line, 1 = fire only on lines where Timer 0 matched.
- T0_IRQ  out  1  one-CE-cycle pulse on Timer 0 match.
- T1_IRQ  out  1  one-CE-cycle pulse on Timer 1 expiry.
- T0_CNT  out  T0_W  current Timer 0 count (debug/status).

## Operation
- Edge detect: HBLANK and VBLANK are registered on CE.
  - hb_in = HBLANK & ~hb_q.
  - vb_out = ~VBLANK & vb_q.
- Timer 0 counter t0:
  - vb_out: t0 <= 0.
  - else hb_in: t0 <= t0+1, modulo 2^T0_W (1023 wraps to 0).
  - vb_out takes priority when both occur in the same cycle.
- Timer 0 match:
  - On the cycle t0 is updated (vb_out or hb_in), compare the new value with T0C.
  - If equal and ENB=1: T0_IRQ pulses and line_match <= 1.
  - Each hb_in first clears line_match and then re-evaluates it.
  - A T0C write alone never fires T0_IRQ; only an update event does.
- Timer 1 states:
  - IDLE -> LOAD on hb_in with ENB=1: t1 <= T1S, armed <= 1.
  - COUNT (armed): on DOT_CE, if t1 != 0 then t1 <= t1-1.
  - If t1 == 0 while armed:
    - Fire T1_IRQ if MD=0, or if MD=1 and line_match=1.
    - In either case armed <= 0 (return to IDLE).
  - At most one T1 expiry per line.
  - An hb_in while still armed reloads t1 and discards the pending expiry (reload wins over decrement).
- ENB=0: t0 held at 0, line_match=0, armed=0, no IRQs. Re-enabling takes effect from the next edge event.
- Reset values: t0=0, t1=0, armed=0, line_match=0, hb_q=0, vb_q=0, T0_IRQ=0, T1_IRQ=0, T0_CNT=0.

## Timing
- Edge detection adds 1 CE cycle. T0_IRQ is registered and asserts 1 CE cycle after the cycle in which hb_in/vb_out is detected, i.e. 2 CE cycles after the HBLANK/VBLANK transition is sampled.
- T1_IRQ asserts 1 CE cycle after the DOT_CE cycle on which t1==0 is seen while armed.
- T1S=0: expiry is seen on the first DOT_CE after LOAD.
- T1S=N: T1_IRQ follows the (N+1)th DOT_CE after LOAD.
- IRQ pulses last exactly one CE cycle. With CE=0 they hold their value.
- Asynchronous reset mid-count clears all state immediately. There is no pending-IRQ carry-over.

## Structure
- Add to the shared SCU package:
  - T0_CNT_W=10 and T1_CNT_W=9 constants.
  - A typedef for the Timer 1 state enum (IDLE/COUNT).
- T1MD_t is reused as-is.
- One natural sub-module: scu_edge_det (registered rise/fall detector with CE), instanced for HBLANK and VBLANK.

## Test plan
- ENB=1, T0C=5, 10 lines after vb_out -> single T0_IRQ on the hb_in that makes t0=5; T0_CNT reads 5 then 6.
- ENB=1, MD=0, T1S=3 -> T1_IRQ on every line, 1 CE after the 4th DOT_CE following each hb_in.
- ENB=1, MD=1, T0C=2, T1S=0 -> T1_IRQ only on the line where t0=2; no T1_IRQ on other lines.
- hb_in and vb_out in the same CE cycle with T0C=0 -> t0=0 and T0_IRQ fires once.
- T1S=400 with a short line (next hb_in before expiry) -> no T1_IRQ; t1 reloaded to 400. ENB=0 mid-line -> no IRQs, T0_CNT=0.
- Assert RST_N=0 mid-count with t0=7, armed=1 -> all outputs 0 immediately; after release, first T0_IRQ only at a new match.
